serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 151 +++++++++++++++
 tb/tb_serial_subtractor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Define SERSUB_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             borrow_q, borrow_d;

   logic             a_bit, b_bit, d_bit, br_nxt, last_bit;
   logic [WIDTH:0]   res_cat;
   logic [WIDTH-1:0] res_nxt;

`ifdef SERSUB_OVF_EN
   logic amsb_q, amsb_d, bmsb_q, bmsb_d, ovf_q, ovf_d;
`endif

   assign a_bit    = a_q[0];
   assign b_bit    = b_q[0];
   assign d_bit    = a_bit ^ b_bit ^ br_q;
   assign br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
   assign last_bit = (cnt_q == CW'(WIDTH - 1));
   // New bit enters at the MSB; concatenating first keeps this legal for WIDTH=1.
   assign res_cat  = {d_bit, res_q};
   assign res_nxt  = res_cat[WIDTH:1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      cnt_d     = cnt_q;
      br_d      = br_q;
      diff_d    = diff_q;
      borrow_d  = borrow_q;
`ifdef SERSUB_OVF_EN
      amsb_d    = amsb_q;
      bmsb_d    = bmsb_q;
      ovf_d     = ovf_q;
`endif
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               res_d   = '0;
               cnt_d   = '0;
               br_d    = 1'b0;
`ifdef SERSUB_OVF_EN
               amsb_d  = a[WIDTH-1];
               bmsb_d  = b[WIDTH-1];
`endif
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = res_nxt;
            br_d  = br_nxt;
            cnt_d = cnt_q + CW'(1);
            if (last_bit) begin
               diff_d   = res_nxt;
               borrow_d = br_nxt;
`ifdef SERSUB_OVF_EN
               ovf_d    = (amsb_q != bmsb_q) && (d_bit != amsb_q);
`endif
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
`ifdef SERSUB_OVF_EN
         amsb_q   <= 1'b0;
         bmsb_q   <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         br_q     <= br_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
`ifdef SERSUB_OVF_EN
         amsb_q   <= amsb_d;
         bmsb_q   <= bmsb_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign diff   = diff_q;
   assign borrow = borrow_q;
`ifdef SERSUB_OVF_EN
   assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): expectations queued at accept, checked at result handshake.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, borrow;
   logic [W-1:0] diff;
`ifdef SERSUB_OVF_EN
   logic         ovf;
`endif

   serial_subtractor #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .diff     (diff),
      .borrow   (borrow)
`ifdef SERSUB_OVF_EN
      ,
      .ovf      (ovf)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   typedef struct {
      logic [W-1:0] d;
      logic         br;
      logic         ov;
      int           acc;
   } exp_t;

   exp_t sb[$];

   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input int c);
      exp_t e;
      e.d   = av - bv;
      e.br  = (av < bv);
      e.ov  = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
      e.acc = c;
      return e;
   endfunction

   // Monitor: sample away from the rising edge.
   logic         hold_v = 1'b0;
   logic [W-1:0] hold_d;
   logic         hold_b;
   exp_t         got;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (in_valid && in_ready) sb.push_back(model(a, b, cyc));
         if (out_valid) begin
            chk("busy_in_ready", in_ready, 0);
            if (hold_v) begin
               chk("hold_diff", diff, hold_d);
               chk("hold_borrow", borrow, hold_b);
            end else begin
               chk("spurious_out", sb.size() != 0, 1);
               if (sb.size() != 0) chk("latency", cyc - sb[0].acc, W + 1);
            end
            hold_v = 1'b1;
            hold_d = diff;
            hold_b = borrow;
            if (out_ready) begin
               hold_v = 1'b0;
               if (sb.size() != 0) begin
                  got = sb.pop_front();
                  chk("diff", diff, got.d);
                  chk("borrow", borrow, got.br);
`ifdef SERSUB_OVF_EN
                  chk("ovf", ovf, got.ov);
`endif
               end
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
      int n = 0;
      in_valid = 1'b1;
      a = av;
      b = bv;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) chk("accept_timeout", n, 0);
      @(posedge clk) #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("drain_timeout", sb.size(), 0);
      @(posedge clk) #1;
   endtask

   bit rnd_on = 1'b0;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [W-1:0] ra, rb;

      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow, 0);
`ifdef SERSUB_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
      @(posedge clk);
      @(posedge clk) #1;
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);

      out_ready = 1'b1;
      send(8'h05, 8'h03);
      drain();

      send(8'h03, 8'h05);
      send(8'h00, 8'hFF);
      send(8'hA5, 8'hA5);
      send(8'h80, 8'h01);
      send(8'h7F, 8'hFF);
      send(8'hFF, 8'h00);
      drain();

      // Consumer stalls; new operands offered while busy must be ignored.
      out_ready = 1'b0;
      send(8'h3C, 8'h11);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("stall_wait_timeout", n, 0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk) #1;
         in_valid = i[0];
         a = W'($urandom);
         b = W'($urandom);
      end
      chk("stall_diff", diff, 8'h2B);
      chk("stall_in_ready", in_ready, 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_in_ready", in_ready, 1);
      chk("release_out_valid", out_valid, 0);
      @(posedge clk) #1;

      // Reset during the fourth SHIFT cycle aborts the operation.
      send(8'h44, 8'h22);
      repeat (3) @(posedge clk);
      #1;
      chk("mid_in_ready", in_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_diff", diff, 0);
      chk("abort_borrow", borrow, 0);
      chk("abort_in_ready", in_ready, 1);
      sb.delete();
      @(posedge clk);
      @(posedge clk) #1;
      rst_n = 1'b1;
      send(8'h10, 8'h01);
      drain();
      chk("post_abort_diff", diff, 8'h0F);

      // Random operands with random consumer back-pressure.
      rnd_on = 1'b1;
      fork
         while (rnd_on) begin
            @(posedge clk) #1;
            out_ready = 1'($urandom_range(0, 1));
         end
      join_none
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         rb = (i % 17 == 0) ? ra : W'($urandom);
         send(ra, rb);
      end
      rnd_on = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      out_ready = 1'b1;
      drain();

      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
